// File: rtl/bus_pkg.sv
// Shared encodings for the two-master shared-bus arbiter: slave responses, FSM states, master indices.
package bus_pkg;

    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [1:0] RESP_ERROR = 2'b01;
    localparam logic [1:0] RESP_RETRY = 2'b10;
    localparam logic [1:0] RESP_SPLIT = 2'b11;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_OWN  = 1'b1
    } arb_state_e;

    localparam logic M1 = 1'b0;
    localparam logic M2 = 1'b1;

endpackage

// File: rtl/arb_pick.sv
// Combinational winner select among eligible masters when the bus is idle.
// Optional feature macro: ARB_ROUND_ROBIN_EN (alternate winner on contention).
module arb_pick
    import bus_pkg::*;
(
    input  logic [1:0] eligible,
    input  logic       last_owner,
    output logic       valid_c,
    output logic       winner_c
);

    assign valid_c = |eligible;

`ifdef ARB_ROUND_ROBIN_EN
    // On contention the master that did not own the bus last goes first.
    always_comb begin
        winner_c = ~eligible[M1];
        if (eligible == 2'b11) begin
            winner_c = ~last_owner;
        end
    end
`else
    logic unused_last_owner;
    assign unused_last_owner = last_owner;

    // Fixed priority: master 1 whenever it is eligible.
    always_comb begin
        winner_c = ~eligible[M1];
    end
`endif

endmodule

// File: rtl/ahb_bus_arbiter.sv
// Two-master shared-bus arbiter: grants, address/data mux selects, burst beat limit, slave responses.
// Optional feature macro: ARB_ROUND_ROBIN_EN (see arb_pick).
module ahb_bus_arbiter
    import bus_pkg::*;
#(
    parameter int unsigned MAX_BEATS = 4,
    parameter int unsigned CNT_W     = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       busreq_1,
    input  logic       busreq_2,
    input  logic       ready,
    input  logic [1:0] response,
    input  logic [1:0] split_done,
    output logic       grant_1,
    output logic       grant_2,
    output logic       mux1,
    output logic       mux2,
    output logic [1:0] split_mask,
    output logic       error
);

    arb_state_e       state;
    logic [CNT_W-1:0] beat_cnt;
    logic             last_owner;

    logic [1:0] eligible_c;
    logic [1:0] mask_clr_c;
    logic       pick_valid_c;
    logic       pick_winner_c;
    logic       owner_req_c;
    logic       other_elig_c;
    logic       at_limit_c;

    // While a grant is high, mux1 identifies the owner.
    assign eligible_c   = {busreq_2, busreq_1} & ~split_mask;
    assign mask_clr_c   = split_mask & ~split_done;
    assign owner_req_c  = (mux1 == M1) ? busreq_1 : busreq_2;
    assign other_elig_c = eligible_c[~mux1];
    assign at_limit_c   = (beat_cnt == CNT_W'(MAX_BEATS - 1));

    arb_pick u_pick (
        .eligible   (eligible_c),
        .last_owner (last_owner),
        .valid_c    (pick_valid_c),
        .winner_c   (pick_winner_c)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            grant_1    <= 1'b0;
            grant_2    <= 1'b0;
            mux1       <= M1;
            mux2       <= M1;
            split_mask <= 2'b00;
            error      <= 1'b0;
            beat_cnt   <= '0;
            last_owner <= M2;
        end else begin
            error      <= 1'b0;
            split_mask <= mask_clr_c;
            case (state)
                ST_IDLE: begin
                    beat_cnt <= '0;
                    if (pick_valid_c) begin
                        state      <= ST_OWN;
                        grant_1    <= (pick_winner_c == M1);
                        grant_2    <= (pick_winner_c == M2);
                        mux1       <= pick_winner_c;
                        last_owner <= pick_winner_c;
                    end
                end
                ST_OWN: begin
                    // Grants only move on a completed beat.
                    if (ready) begin
                        case (response)
                            RESP_OKAY: begin
                                mux2 <= mux1;
                                if (!owner_req_c || at_limit_c) begin
                                    beat_cnt <= '0;
                                end else begin
                                    beat_cnt <= beat_cnt + CNT_W'(1);
                                end
                                if ((!owner_req_c || at_limit_c) && other_elig_c) begin
                                    grant_1    <= ~grant_1;
                                    grant_2    <= ~grant_2;
                                    mux1       <= ~mux1;
                                    last_owner <= ~mux1;
                                end else if (!owner_req_c) begin
                                    state   <= ST_IDLE;
                                    grant_1 <= 1'b0;
                                    grant_2 <= 1'b0;
                                end
                            end
                            RESP_RETRY: begin
                            end
                            RESP_SPLIT: begin
                                split_mask <= mask_clr_c | (2'b01 << mux1);
                                beat_cnt   <= '0;
                                if (other_elig_c) begin
                                    grant_1    <= ~grant_1;
                                    grant_2    <= ~grant_2;
                                    mux1       <= ~mux1;
                                    last_owner <= ~mux1;
                                end else begin
                                    state   <= ST_IDLE;
                                    grant_1 <= 1'b0;
                                    grant_2 <= 1'b0;
                                end
                            end
                            RESP_ERROR: begin
                                error    <= 1'b1;
                                beat_cnt <= '0;
                                state    <= ST_IDLE;
                                grant_1  <= 1'b0;
                                grant_2  <= 1'b0;
                            end
                        endcase
                    end
                end
            endcase
        end
    end

endmodule
